// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive demultiplexer.
package tdm_pkg;

   // Largest frame the demux is meant to be built for.
   localparam int unsigned NUM_CH_MAX = 16;

   // Frame alignment state.
   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_e;

   // Bit offset of channel ch inside a flat bank of w-bit lanes.
   function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position counter: load-to-1 on frame start, advance on accepted beats,
// wrap after the last slot, flag the last slot.
module tdm_slot_counter #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned SLOT_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              load1_i,
   output logic [SLOT_W-1:0] slot_o,
   output logic              tc_o
);

   logic [SLOT_W-1:0] slot_q, slot_d;

   assign tc_o   = (slot_q == SLOT_W'(NUM_CH - 1));
   assign slot_o = slot_q;

   // Next slot: frame start wins over plain advance; advance wraps at the last slot.
   always_comb begin
      slot_d = slot_q;
      if (load1_i)
         slot_d = SLOT_W'(1);
      else if (en_i)
         slot_d = tc_o ? '0 : slot_q + SLOT_W'(1);
   end

   // Slot register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) slot_q <= '0;
      else     slot_q <= slot_d;
   end

endmodule

// File: rtl/tdm_demux.sv
// Frame-synchronised TDM demultiplexer: hunts for the slot-0 marker, stages
// samples per channel and publishes whole frames with a one-cycle pulse.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_CH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_sof,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     frame_valid,
   output logic                     locked,
   output logic                     sync_err
);

   localparam int unsigned SLOT_W = $clog2(NUM_CH);

   tdm_state_e              state_q, state_d;
   logic [SLOT_W-1:0]       slot;
   logic                    slot_tc;
   logic                    cnt_en, cnt_load1;
   logic                    wr_en;
   logic [SLOT_W-1:0]       wr_idx;
   logic                    publish;
   logic                    fv_d, se_d;
   logic [NUM_CH*DATA_W-1:0] staging_q, bank_d, out_q;
   logic                    fv_q, se_q;

   tdm_slot_counter #(.NUM_CH(NUM_CH), .SLOT_W(SLOT_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .en_i    (cnt_en),
      .load1_i (cnt_load1),
      .slot_o  (slot),
      .tc_o    (slot_tc)
   );

   // Alignment FSM: decides writes, slot movement, publish and error pulses per beat.
   always_comb begin
      state_d   = state_q;
      cnt_en    = 1'b0;
      cnt_load1 = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = slot;
      publish   = 1'b0;
      fv_d      = 1'b0;
      se_d      = 1'b0;
      case (state_q)
         HUNT: begin
            if (in_valid && in_sof) begin
               wr_en     = 1'b1;
               wr_idx    = '0;
               cnt_load1 = 1'b1;
               state_d   = LOCKED;
            end
         end
         LOCKED: begin
            if (in_valid) begin
               if (in_sof) begin
                  // Early marker abandons the partial frame and restarts at slot 0.
                  se_d      = (slot != '0);
                  wr_en     = 1'b1;
                  wr_idx    = '0;
                  cnt_load1 = 1'b1;
               end else if (slot == '0) begin
                  // Missing marker: drop the beat and go back to hunting.
                  se_d    = 1'b1;
                  state_d = HUNT;
               end else if (slot_tc) begin
                  publish = 1'b1;
                  fv_d    = 1'b1;
                  cnt_en  = 1'b1;
               end else begin
                  wr_en  = 1'b1;
                  cnt_en = 1'b1;
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   // Published bank: staged channels plus the last channel straight from the wire.
   always_comb begin
      bank_d = staging_q;
      bank_d[ch_lsb(NUM_CH - 1, DATA_W) +: DATA_W] = in_data;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= HUNT;
      else     state_q <= state_d;
   end

   // Staging, output bank and registered pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         staging_q <= '0;
         out_q     <= '0;
         fv_q      <= 1'b0;
         se_q      <= 1'b0;
      end else begin
         if (wr_en)   staging_q[ch_lsb(32'(wr_idx), DATA_W) +: DATA_W] <= in_data;
         if (publish) out_q <= bank_d;
         fv_q <= fv_d;
         se_q <= se_d;
      end
   end

   assign out_data    = out_q;
   assign frame_valid = fv_q;
   assign sync_err    = se_q;
   assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a 2-channel and a 4-channel instance.
module tb_tdm_demux;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        v2 = 1'b0, s2 = 1'b0, v4 = 1'b0, s4 = 1'b0;
   logic [7:0]  d2 = '0, d4 = '0;
   logic [15:0] od2;
   logic [31:0] od4;
   logic        fv2, lk2, se2, fv4, lk4, se4;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   tdm_demux #(.DATA_W(8), .NUM_CH(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_sof(s2),
      .out_data(od2), .frame_valid(fv2), .locked(lk2), .sync_err(se2)
   );

   tdm_demux #(.DATA_W(8), .NUM_CH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_sof(s4),
      .out_data(od4), .frame_valid(fv4), .locked(lk4), .sync_err(se4)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One beat on the 2-channel link; returns at the next falling edge.
   task automatic beat2(input logic v, input logic s, input logic [7:0] d);
      v2 = v; s2 = s; d2 = d;
      @(negedge clk);
      v2 = 1'b0; s2 = 1'b0;
   endtask

   task automatic beat4(input logic v, input logic s, input logic [7:0] d);
      v4 = v; s4 = s; d4 = d;
      @(negedge clk);
      v4 = 1'b0; s4 = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out",  32'(od2), 32'h0);
      chk("rst_lock", 32'(lk2), 32'h0);
      chk("rst_fv",   32'(fv2), 32'h0);
      chk("rst_se",   32'(se2), 32'h0);
      chk("rst_out4", od4,      32'h0);

      // Hunt: non-marker dropped, marker locks, second slot publishes.
      beat2(1'b1, 1'b0, 8'h11);
      chk("hunt_drop_lk", 32'(lk2), 32'h0);
      chk("hunt_drop_fv", 32'(fv2), 32'h0);
      beat2(1'b1, 1'b1, 8'hA5);
      chk("lock_rise", 32'(lk2), 32'h1);
      chk("lock_fv",   32'(fv2), 32'h0);
      beat2(1'b1, 1'b0, 8'h3C);
      chk("f1_fv",  32'(fv2), 32'h1);
      chk("f1_out", 32'(od2), 32'h3CA5);
      @(negedge clk);
      chk("f1_pulse_end", 32'(fv2), 32'h0);
      chk("f1_hold",      32'(od2), 32'h3CA5);

      // Back-to-back frames.
      beat2(1'b1, 1'b1, 8'h01);
      chk("b2b_gap", 32'(fv2), 32'h0);
      beat2(1'b1, 1'b0, 8'h02);
      chk("b2b_fv1",  32'(fv2), 32'h1);
      chk("b2b_out1", 32'(od2), 32'h0201);
      beat2(1'b1, 1'b1, 8'h03);
      chk("b2b_gap2", 32'(fv2), 32'h0);
      beat2(1'b1, 1'b0, 8'h04);
      chk("b2b_fv2",  32'(fv2), 32'h1);
      chk("b2b_out2", 32'(od2), 32'h0403);

      // Missing marker at slot 0.
      beat2(1'b1, 1'b0, 8'h77);
      chk("miss_se",  32'(se2), 32'h1);
      chk("miss_lk",  32'(lk2), 32'h0);
      chk("miss_fv",  32'(fv2), 32'h0);
      chk("miss_out", 32'(od2), 32'h0403);
      @(negedge clk);
      chk("miss_se_end", 32'(se2), 32'h0);
      beat2(1'b1, 1'b0, 8'h55);
      chk("miss_hunt_lk", 32'(lk2), 32'h0);
      chk("miss_hunt_se", 32'(se2), 32'h0);
      beat2(1'b1, 1'b1, 8'h66);
      chk("relock", 32'(lk2), 32'h1);
      beat2(1'b1, 1'b0, 8'h99);
      chk("relock_fv",  32'(fv2), 32'h1);
      chk("relock_out", 32'(od2), 32'h9966);

      // Early marker on 2 channels.
      beat2(1'b1, 1'b1, 8'h12);
      beat2(1'b1, 1'b1, 8'h34);
      chk("early2_se", 32'(se2), 32'h1);
      chk("early2_fv", 32'(fv2), 32'h0);
      chk("early2_lk", 32'(lk2), 32'h1);
      beat2(1'b1, 1'b0, 8'h56);
      chk("early2_se_end", 32'(se2), 32'h0);
      chk("early2_fv2",    32'(fv2), 32'h1);
      chk("early2_out",    32'(od2), 32'h5634);

      // Early marker on 4 channels.
      beat4(1'b1, 1'b1, 8'h0A);
      beat4(1'b1, 1'b0, 8'h0B);
      beat4(1'b1, 1'b1, 8'h0C);
      chk("early4_se", 32'(se4), 32'h1);
      chk("early4_fv", 32'(fv4), 32'h0);
      chk("early4_lk", 32'(lk4), 32'h1);
      beat4(1'b1, 1'b0, 8'h0D);
      chk("early4_se_end", 32'(se4), 32'h0);
      chk("early4_fv_d",   32'(fv4), 32'h0);
      beat4(1'b1, 1'b0, 8'h0E);
      chk("early4_fv_e",   32'(fv4), 32'h0);
      beat4(1'b1, 1'b0, 8'h0F);
      chk("f4_fv",  32'(fv4), 32'h1);
      chk("f4_out", od4,      32'h0F0E0D0C);

      // Async reset mid-frame, then a frame with an idle gap inside.
      beat2(1'b1, 1'b1, 8'hAA);
      #2 rst = 1'b1;
      #1;
      chk("arst_out",  32'(od2), 32'h0);
      chk("arst_lk",   32'(lk2), 32'h0);
      chk("arst_fv",   32'(fv2), 32'h0);
      chk("arst_out4", od4,      32'h0);
      @(negedge clk);
      rst = 1'b0;
      beat2(1'b1, 1'b0, 8'hBB);
      chk("post_rst_fv", 32'(fv2), 32'h0);
      chk("post_rst_lk", 32'(lk2), 32'h0);
      beat2(1'b1, 1'b1, 8'hC1);
      chk("gap_lock", 32'(lk2), 32'h1);
      @(negedge clk);
      @(negedge clk);
      chk("gap_fv", 32'(fv2), 32'h0);
      chk("gap_lk", 32'(lk2), 32'h1);
      beat2(1'b1, 1'b0, 8'hC2);
      chk("gap_fv2", 32'(fv2), 32'h1);
      chk("gap_out", 32'(od2), 32'hC2C1);
      chk("gap_se",  32'(se2), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Frame-synchronised time-division demultiplexer. It is the receive-side counterpart of the team's 2:1 multiplexer path.
- Accepts a serial stream of DATA_W-bit samples, one per slot, with slot 0 flagged by a start-of-frame marker.
- Routes each sample to its channel staging register. Presents a complete, frame-aligned bank of channel values with a one-cycle frame_valid pulse.
- Sits between the TDM link and the per-channel consumers. It hunts for frame alignment, tracks slot position and flags sync errors.

Parameters:
- DATA_W, 8, width of one sample/channel word.
- NUM_CH, 2, channels per frame; legal range 2..16.
- SLOT_W, $clog2(NUM_CH), derived local parameter; width of the slot counter. Not user-overridable.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies in_data/in_sof; a beat is accepted only when high. There is no backpressure.
- in_data  input  DATA_W  sample for the current slot.
- in_sof  input  1  high on the slot-0 beat of each frame; ignored when in_valid is low.
- out_data  output  NUM_CH*DATA_W  frame bank; channel k occupies bits [k*DATA_W +: DATA_W].
- frame_valid  output  1  one-cycle pulse: out_data holds a new complete frame.
- locked  output  1  high while frame alignment is held.
- sync_err  output  1  one-cycle pulse on any alignment violation.

Behaviour:
- Reset (async assert, sync release): state=HUNT, slot=0, staging regs=0, out_data=0, frame_valid=0, locked=0, sync_err=0.
- States: HUNT, LOCKED. locked is 1 exactly in LOCKED and is registered.
- HUNT:
  - Beats with in_sof=0 are dropped silently.
  - A beat with in_valid&in_sof writes staging[0], sets slot=1 and moves to LOCKED.
- LOCKED, accepted beat with slot!=0 and in_sof=0: write staging[slot]; slot increments.
- LOCKED, beat that completes a frame (slot==NUM_CH-1, in_sof=0):
  - out_data <= staging with channel NUM_CH-1 taken directly from in_data.
  - frame_valid=1 next cycle; slot wraps to 0.
- LOCKED, slot==0 with in_sof=1: normal frame start; write staging[0], slot=1.
- LOCKED, slot==0 with in_sof=0 (missing marker):
  - sync_err pulse and beat dropped.
  - Go to HUNT; locked falls next cycle.
- LOCKED, slot!=0 with in_sof=1 (early marker):
  - sync_err pulse and the partial frame is discarded (no frame_valid).
  - The beat is treated as slot 0 of a new frame; slot=1; stay LOCKED.
- in_valid=0: no state change; slot holds (idle gaps inside a frame are legal).
- Latency: frame_valid and the out_data update are registered, one cycle after the last-slot beat. sync_err is also one cycle after the offending beat.
- out_data holds its value until the next complete frame; never partially updated.
- Staging registers are not cleared between frames. Only complete frames are ever published, so stale staging data is never visible.
- frame_valid and sync_err are never high in the same cycle.
- Back-to-back frames with no idle beats sustain one frame_valid per NUM_CH cycles.
- rst asserted mid-frame: immediate return to reset values; the partial frame is lost and no pulse is produced.

Decomposition:
- Package tdm_pkg:
  - state enum (HUNT, LOCKED);
  - NUM_CH_MAX=16 constant;
  - slot-index helper function (channel lane offset).
- One natural sub-module, tdm_slot_counter. It is a SLOT_W counter with enable, synchronous load-to-1 on frame start, wrap at NUM_CH-1 and a terminal-count flag.
- FSM, staging and output bank stay in tdm_demux.

Test Plan (NUM_CH=2, DATA_W=8 unless noted):
- Reset then no stimulus -> out_data=16'h0000, locked=0, frame_valid=0, sync_err=0.
- HUNT with beats 8'h11 (sof=0), then 8'hA5 (sof=1), 8'h3C (sof=0):
  - 8'h11 is dropped; locked rises after 8'hA5.
  - frame_valid pulses once, the cycle after 8'h3C, with out_data=16'h3CA5.
- Continuous frames {01,02},{03,04} with no gaps -> frame_valid pulses 2 cycles apart; out_data=16'h0201 then 16'h0403.
- Locked, then beat sof=0 at slot 0 -> sync_err one pulse, locked=0; out_data keeps its last frame; relock on the next sof beat.
- NUM_CH=4: sof,0A; 0B; then sof,0C; 0D; 0E; 0F:
  - sync_err on the early sof; no frame_valid for the partial frame.
  - Then frame_valid with out_data=32'h0F0E0D0C.
- rst pulsed mid-frame, with an idle gap inserted inside the next frame -> all outputs return to 0 immediately; the frame after relock still assembles correctly across the gap.
